multicycle_control: RTL and testbench



---
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_control_if #(
   parameter int COUNT_W = 16
);
   // Memory handshake: a request (MemRead or MemWrite) is held steady until
   // the memory returns MemReady in the same cycle; that cycle completes the
   // transfer and the controller never issues a new request in it.
   logic [3:0]         input_Opcode;
   logic               input_Zero;
   logic               input_MemReady;
   logic [3:0]         output_ALUOp;
   logic               output_ALUSrcA;
   logic [1:0]         output_ALUSrcB;
   logic               output_PCWrite;
   logic [1:0]         output_PCSrc;
   logic               output_IorD;
   logic               output_MemRead;
   logic               output_MemWrite;
   logic               output_IRWrite;
   logic               output_RegWrite;
   logic               output_RegDst;
   logic               output_MemToReg;
   logic [3:0]         output_State;
   logic [COUNT_W-1:0] output_InstrCount;

   modport master (
      input  input_Opcode, input_Zero, input_MemReady,
      output output_ALUOp, output_ALUSrcA, output_ALUSrcB, output_PCWrite,
      output output_PCSrc, output_IorD, output_MemRead, output_MemWrite,
      output output_IRWrite, output_RegWrite, output_RegDst, output_MemToReg,
      output output_State, output_InstrCount
   );

   modport slave (
      output input_Opcode, input_Zero, input_MemReady,
      input  output_ALUOp, output_ALUSrcA, output_ALUSrcB, output_PCWrite,
      input  output_PCSrc, output_IorD, output_MemRead, output_MemWrite,
      input  output_IRWrite, output_RegWrite, output_RegDst, output_MemToReg,
      input  output_State, output_InstrCount
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multi-cycle processor: fetch/decode/execute/
// memory/writeback sequencing plus a retired-instruction counter.
module multicycle_control #(
   parameter int COUNT_W = 16
) (
   input  logic                 input_CLK,
   input  logic                 input_Reset,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_ALU_WB   = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [3:0] OP_RTYPE_MAX = 4'b1001;
   localparam logic [3:0] OP_ADDI      = 4'b1010;
   localparam logic [3:0] OP_LW        = 4'b1011;
   localparam logic [3:0] OP_LUI       = 4'b1100;
   localparam logic [3:0] OP_SW        = 4'b1101;
   localparam logic [3:0] OP_BEQ       = 4'b1110;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_PASSB = 4'b1100;

   state_t             state_q, state_d;
   logic [3:0]         op_q;
   logic [COUNT_W-1:0] count_q;
   logic               retire;

   logic [3:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;

   always_ff @(posedge input_CLK or posedge input_Reset) begin
      if (input_Reset) begin
         state_q <= S_IDLE;
         op_q    <= 4'd0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            op_q <= bus.input_Opcode;
         if (retire)
            count_q <= count_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = S_IDLE;
      retire     = 1'b0;
      alu_op     = ALU_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            // PC <= PC + 1 and IR load happen only on the completing cycle.
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = bus.input_MemReady;
            pc_write  = bus.input_MemReady;
            state_d   = bus.input_MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = 2'b10;
            if (bus.input_Opcode <= OP_RTYPE_MAX)
               state_d = S_EXEC_R;
            else if (bus.input_Opcode == OP_ADDI || bus.input_Opcode == OP_LUI)
               state_d = S_EXEC_I;
            else if (bus.input_Opcode == OP_LW || bus.input_Opcode == OP_SW)
               state_d = S_MEM_ADDR;
            else if (bus.input_Opcode == OP_BEQ)
               state_d = S_BRANCH;
            else
               state_d = S_JUMP;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = op_q;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = (op_q == OP_LUI) ? ALU_PASSB : ALU_ADD;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = (op_q <= OP_RTYPE_MAX);
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            state_d  = bus.input_MemReady ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            retire    = bus.input_MemReady;
            state_d   = bus.input_MemReady ? S_FETCH : S_MEM_WR;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 2'b01;
            pc_write  = bus.input_Zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.output_ALUOp      = alu_op;
   assign bus.output_ALUSrcA    = alu_src_a;
   assign bus.output_ALUSrcB    = alu_src_b;
   assign bus.output_PCWrite    = pc_write;
   assign bus.output_PCSrc      = pc_src;
   assign bus.output_IorD       = iord;
   assign bus.output_MemRead    = mem_read;
   assign bus.output_MemWrite   = mem_write;
   assign bus.output_IRWrite    = ir_write;
   assign bus.output_RegWrite   = reg_write;
   assign bus.output_RegDst     = reg_dst;
   assign bus.output_MemToReg   = mem_to_reg;
   assign bus.output_State      = state_q;
   assign bus.output_InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference model,
// per-cycle output compare, directed state traces and counter-wrap checks.
module tb_multicycle_control;

   localparam int CW = 4;

   logic clk;
   logic rst;

   multicycle_control_if #(.COUNT_W(CW)) bus();

   multicycle_control #(.COUNT_W(CW)) dut (
      .input_CLK   (clk),
      .input_Reset (rst),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      int         fetch_wait;
      int         mem_wait;
      logic       zero;
   } instr_t;

   int     n_checks = 0;
   int     n_errors = 0;
   instr_t desc_q[$];
   int     phase_q[$];
   int     m_state   = 0;
   logic [3:0] m_op  = 4'd0;
   int     m_count   = 0;
   int     m_retired = 0;
   logic   trace_on  = 1'b0;
   int     trace_q[$];

   // Expected control vector for a phase, straight from the state output table.
   function automatic logic [20:0] expect_vec(input int st, input logic [3:0] op,
                                              input logic rdy, input logic z);
      logic [3:0] alu_op, st_v;
      logic       src_a, pc_w, iord, mrd, mwr, irw, rw, rdst, m2r;
      logic [1:0] src_b, pc_src;
      alu_op = 4'd0; src_a = 1'b0; src_b = 2'd0; pc_w = 1'b0; pc_src = 2'd0;
      iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0; rw = 1'b0; rdst = 1'b0; m2r = 1'b0;
      st_v = st[3:0];
      case (st)
         1:  begin mrd = 1'b1; src_b = 2'd1; irw = rdy; pc_w = rdy; end
         2:  src_b = 2'd2;
         3:  begin src_a = 1'b1; alu_op = op; end
         4:  begin src_a = 1'b1; src_b = 2'd2; alu_op = (op == 4'd12) ? 4'd12 : 4'd0; end
         5:  begin rw = 1'b1; rdst = (op <= 4'd9); end
         6:  begin src_a = 1'b1; src_b = 2'd2; end
         7:  begin mrd = 1'b1; iord = 1'b1; end
         8:  begin rw = 1'b1; m2r = 1'b1; end
         9:  begin mwr = 1'b1; iord = 1'b1; end
         10: begin src_a = 1'b1; alu_op = 4'd1; pc_src = 2'd1; pc_w = z; end
         11: begin pc_src = 2'd2; pc_w = 1'b1; end
         default: ;
      endcase
      return {alu_op, src_a, src_b, pc_w, pc_src, iord, mrd, mwr, irw, rw, rdst, m2r, st_v};
   endfunction

   // Instruction-level view: each opcode expands to a fixed list of post-decode phases.
   task automatic plan_phases(input logic [3:0] op);
      phase_q.delete();
      if (op <= 4'd9)                    phase_q = '{3, 5};
      else if (op == 4'd10 || op == 4'd12) phase_q = '{4, 5};
      else if (op == 4'd11)              phase_q = '{6, 7, 8};
      else if (op == 4'd13)              phase_q = '{6, 9};
      else if (op == 4'd14)              phase_q = '{10};
      else                               phase_q = '{11};
   endtask

   task automatic next_phase();
      if (phase_q.size() == 0) begin
         m_state   = 1;
         m_count   = (m_count + 1) % (1 << CW);
         m_retired = m_retired + 1;
      end else begin
         m_state = phase_q.pop_front();
      end
   endtask

   always @(negedge clk) begin : compare
      logic [20:0] exp_v, act_v;
      if (rst) begin
         m_state = 0; m_op = 4'd0; m_count = 0; phase_q.delete();
      end
      exp_v = expect_vec(m_state, m_op, bus.input_MemReady, bus.input_Zero);
      act_v = {bus.output_ALUOp, bus.output_ALUSrcA, bus.output_ALUSrcB, bus.output_PCWrite,
               bus.output_PCSrc, bus.output_IorD, bus.output_MemRead, bus.output_MemWrite,
               bus.output_IRWrite, bus.output_RegWrite, bus.output_RegDst, bus.output_MemToReg,
               bus.output_State};
      n_checks++;
      if (act_v !== exp_v) begin
         n_errors++;
         $display("FAIL outputs t=%0t state_exp=%0d actual=%h required=%h", $time, m_state, act_v, exp_v);
      end
      n_checks++;
      if (bus.output_InstrCount !== m_count[CW-1:0]) begin
         n_errors++;
         $display("FAIL instr_count t=%0t actual=%0d required=%0d", $time, bus.output_InstrCount, m_count);
      end
      if (trace_on) trace_q.push_back(int'(bus.output_State));
      if (!rst) begin
         case (m_state)
            0: m_state = 1;
            1: if (bus.input_MemReady) m_state = 2;
            2: begin
               m_op = bus.input_Opcode;
               plan_phases(bus.input_Opcode);
               next_phase();
            end
            7, 9: if (bus.input_MemReady) next_phase();
            default: next_phase();
         endcase
      end
   end

   // Driver: inputs follow the current instruction descriptor where they matter, random elsewhere.
   initial begin : driver
      int     prev;
      int     wcnt;
      instr_t cur;
      prev = 0; wcnt = 0;
      cur = '{op: 4'd0, fetch_wait: 0, mem_wait: 0, zero: 1'b0};
      bus.input_Opcode = 4'd0; bus.input_Zero = 1'b0; bus.input_MemReady = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.input_Opcode   = 4'($urandom_range(0, 15));
         bus.input_MemReady = 1'($urandom_range(0, 1));
         bus.input_Zero     = 1'($urandom_range(0, 1));
         case (m_state)
            1: begin
               if (prev != 1) begin
                  if (desc_q.size() > 0) cur = desc_q.pop_front();
                  else cur = '{op: 4'($urandom_range(0, 15)), fetch_wait: $urandom_range(0, 2),
                               mem_wait: $urandom_range(0, 2), zero: 1'($urandom_range(0, 1))};
                  wcnt = cur.fetch_wait;
               end
               bus.input_MemReady = (wcnt == 0);
               if (wcnt > 0) wcnt--;
            end
            2: begin
               bus.input_Opcode = cur.op;
               wcnt = cur.mem_wait;
            end
            7, 9: begin
               bus.input_MemReady = (wcnt == 0);
               if (wcnt > 0) wcnt--;
            end
            10: bus.input_Zero = cur.zero;
            default: ;
         endcase
         prev = m_state;
      end
   end

   task automatic check_lit(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic wait_retired(input int tgt, input int budget, input string name);
      int n;
      n = 0;
      while (m_retired < tgt && n < budget) begin
         @(posedge clk);
         n++;
      end
      n_checks++;
      if (m_retired < tgt) begin
         n_errors++;
         $display("FAIL %s timeout retired=%0d required=%0d", name, m_retired, tgt);
      end
   endtask

   task automatic push_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
      desc_q.push_back('{op: op, fetch_wait: fw, mem_wait: mw, zero: z});
   endtask

   initial begin : main
      int exp_trace[36];
      int tgt;
      int n;
      exp_trace = '{0, 1,1,1,1, 2,3,5, 1,2,6,7,7,8, 1,2,10, 1,2,10, 1,2,6,9,
                    1,2,4,5, 1,2,4,5, 1,2,11, 1};
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_lit("reset_state", int'(bus.output_State), 0);
      check_lit("reset_count", int'(bus.output_InstrCount), 0);
      check_lit("reset_memread", int'(bus.output_MemRead), 0);

      // Directed program: R-type with 3 fetch waits, lw with one wait, beq taken/not, sw, addi, lui, jmp.
      push_instr(4'd2,  3, 0, 1'b0);
      push_instr(4'd11, 0, 1, 1'b0);
      push_instr(4'd14, 0, 0, 1'b1);
      push_instr(4'd14, 0, 0, 1'b0);
      push_instr(4'd13, 0, 0, 1'b0);
      push_instr(4'd10, 0, 0, 1'b0);
      push_instr(4'd12, 0, 0, 1'b0);
      push_instr(4'd15, 0, 0, 1'b0);
      tgt = m_retired + 8;
      @(posedge clk); #1;
      rst = 1'b0;
      trace_on = 1'b1;
      wait_retired(tgt, 200, "directed");
      @(negedge clk);
      check_lit("directed_count", int'(bus.output_InstrCount), 8);
      #1 trace_on = 1'b0;
      check_lit("trace_len_ok", int'(trace_q.size() >= 36), 1);
      n = (trace_q.size() < 36) ? trace_q.size() : 36;
      for (int i = 0; i < n; i++) check_lit($sformatf("trace[%0d]", i), trace_q[i], exp_trace[i]);

      // Counter wrap: 16 jumps from reset bring a 4-bit count back to zero.
      @(posedge clk); #1 rst = 1'b1;
      desc_q.delete();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 16; i++) push_instr(4'd15, 0, 0, 1'b0);
      tgt = m_retired + 15;
      #1 rst = 1'b0;
      wait_retired(tgt, 200, "wrap15");
      @(negedge clk);
      check_lit("count_before_wrap", int'(bus.output_InstrCount), 15);
      wait_retired(tgt + 1, 50, "wrap16");
      @(negedge clk);
      check_lit("count_after_wrap", int'(bus.output_InstrCount), 0);

      // Randomized instruction stream.
      for (int i = 0; i < 400; i++)
         push_instr(4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)));
      tgt = m_retired + 400;
      wait_retired(tgt, 6000, "random");

      // Reset in the middle of a stalled lw read.
      push_instr(4'd11, 0, 4, 1'b0);
      n = 0;
      while (m_state != 7 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check_lit("reached_mem_rd", m_state, 7);
      #1 rst = 1'b1;
      @(negedge clk);
      check_lit("midreset_state", int'(bus.output_State), 0);
      check_lit("midreset_count", int'(bus.output_InstrCount), 0);
      @(posedge clk); #1 rst = 1'b0;
      tgt = m_retired + 5;
      wait_retired(tgt, 200, "post_reset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
